// File: rtl/fixedpoint_pkg.sv
// Shared fixed-point definitions: accumulator FSM states and width derivation
// helpers used by both the accumulator and the multiplier.
package fixedpoint_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_e;

    function automatic int calc_w(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    function automatic int calc_cw(input int acc_len);
        return $clog2(acc_len + 1);
    endfunction

    // Accumulator width wide enough that a full frame of all-ones never wraps.
    function automatic int calc_aw(input int int_bits, input int frac_bits, input int acc_len);
        return calc_w(int_bits, frac_bits) + calc_cw(acc_len);
    endfunction

endpackage

// File: rtl/fixedpoint_saturate.sv
// Clamps a wide unsigned value to OUT_W bits, flagging when clamping occurred.
module fixedpoint_saturate #(
    parameter int IN_W  = 21,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  value_i,
    output logic [OUT_W-1:0] value_o,
    output logic             overflow_o
);

    assign overflow_o = |value_i[IN_W-1:OUT_W];
    assign value_o    = overflow_o ? {OUT_W{1'b1}} : value_i[OUT_W-1:0];

endmodule

// File: rtl/fixedpoint_accumulator.sv
// Frame accumulator for unsigned fixed-point samples: sums up to ACC_LEN samples,
// then holds the saturated sum until the downstream consumer takes it.
module fixedpoint_accumulator
    import fixedpoint_pkg::*;
#(
    parameter  int INTEGER_BITWIDTH  = 8,
    parameter  int FRACTION_BITWIDTH = 8,
    parameter  int ACC_LEN           = 16,
    localparam int W  = calc_w(INTEGER_BITWIDTH, FRACTION_BITWIDTH),
    localparam int CW = calc_cw(ACC_LEN),
    localparam int AW = calc_aw(INTEGER_BITWIDTH, FRACTION_BITWIDTH, ACC_LEN)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic          out_overflow,
    output logic [CW-1:0] out_count
);

    localparam logic [CW-1:0] LAST_IDX = CW'(ACC_LEN - 1);

    acc_state_e    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [CW-1:0] count_q, count_d;
    logic          in_ready_q, in_ready_d;
    logic          accept;

    logic [W-1:0]  sat_data;
    logic          sat_overflow;

    assign accept = in_valid && in_ready_q && (state_q == ST_ACCUM);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        if (clr) begin
            state_d = ST_ACCUM;
            acc_d   = '0;
            count_d = '0;
        end else begin
            unique case (state_q)
                ST_ACCUM: begin
                    if (accept) begin
                        acc_d   = acc_q + AW'(in_data);
                        count_d = count_q + 1'b1;
                        if ((count_q == LAST_IDX) || in_last) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = ST_ACCUM;
                        acc_d   = '0;
                        count_d = '0;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
        // Ready is registered so it stays low for the whole reset and the HOLD phase.
        in_ready_d = (state_d == ST_ACCUM);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            count_q    <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
        end
    end

    fixedpoint_saturate #(
        .IN_W  (AW),
        .OUT_W (W)
    ) u_saturate (
        .value_i    (acc_q),
        .value_o    (sat_data),
        .overflow_o (sat_overflow)
    );

    assign in_ready     = in_ready_q;
    assign out_valid    = (state_q == ST_HOLD);
    assign out_data     = out_valid ? sat_data : '0;
    assign out_overflow = out_valid ? sat_overflow : 1'b0;
    assign out_count    = out_valid ? count_q : '0;

endmodule

// File: tb/tb_fixedpoint_accumulator.sv
// Directed bench for fixedpoint_accumulator; expected frames are queued by the
// stimulus and checked by an independent output monitor.
module tb_fixedpoint_accumulator;

    localparam int W  = 16;
    localparam int CW = 5;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          ovf;
        logic [CW-1:0] count;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          out_overflow;
    logic [CW-1:0] out_count;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    fixedpoint_accumulator dut (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (clr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per output handshake; outputs must read 0 in ACCUM.
    always @(negedge clk) begin
        if (rstn) begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%0h required=none", out_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("frame_data", 32'(out_data), 32'(e.data));
                    chk("frame_ovf", 32'(out_overflow), 32'(e.ovf));
                    chk("frame_count", 32'(out_count), 32'(e.count));
                    $display("frame data=%h ovf=%0b count=%0d", out_data, out_overflow, out_count);
                end
            end else if (!out_valid) begin
                chk("accum_outputs_zero", {15'd0, out_overflow, 11'd0, out_count} | 32'(out_data), 32'd0);
            end
        end
    end

    // Called at posedge+1; presents a sample and returns at posedge+1 after it is accepted.
    task automatic send(input logic [W-1:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] d, input int n, input bit use_last);
        for (int i = 0; i < n; i++) send(d, use_last && (i == n - 1));
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        chk("hold_in_ready", 32'(in_ready), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_data", 32'(out_data), 32'd0);
        chk("reset_out_count", 32'(out_count), 32'd0);
        #19 rstn = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // 16 x 1.0 -> 16.0
        exp_q.push_back('{data: 16'h1000, ovf: 1'b0, count: 5'd16});
        send_frame(16'h0100, 16, 1'b0);
        idle(1);
        chk("valid_one_cycle", 32'(out_valid), 32'd0);

        // 16 x 0xFFFF saturates
        exp_q.push_back('{data: 16'hFFFF, ovf: 1'b1, count: 5'd16});
        send_frame(16'hFFFF, 16, 1'b0);
        idle(2);

        // early close with in_last; in_last alone in between has no effect
        exp_q.push_back('{data: 16'h0180, ovf: 1'b0, count: 5'd3});
        send(16'h0080, 1'b0);
        in_last = 1'b1;
        idle(1);
        in_last = 1'b0;
        chk("last_without_valid", 32'(out_valid), 32'd0);
        send(16'h0080, 1'b0);
        send(16'h0080, 1'b1);
        chk("last_latency", 32'(out_valid), 32'd1);
        idle(2);

        // mixed values: 0x1234+0x2345+0x0011+0x0100 = 0x368A
        exp_q.push_back('{data: 16'h368A, ovf: 1'b0, count: 5'd4});
        send(16'h1234, 1'b0);
        send(16'h2345, 1'b0);
        send(16'h0011, 1'b0);
        send(16'h0100, 1'b1);
        idle(2);

        // backpressure: 16 x 0x0010 = 0x0100 held for 5 cycles with junk on the input
        exp_q.push_back('{data: 16'h0100, ovf: 1'b0, count: 5'd16});
        out_ready = 1'b0;
        send_frame(16'h0010, 16, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'h5555;
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_ready", 32'(in_ready), 32'd0);
            chk("hold_data", 32'(out_data), 32'h0100);
            chk("hold_count", 32'(out_count), 32'd16);
            idle(1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(1);
        chk("release_valid", 32'(out_valid), 32'd0);
        chk("release_ready", 32'(in_ready), 32'd1);

        // clr aborts a partial frame and drops the sample presented with it
        exp_q.push_back('{data: 16'h0010, ovf: 1'b0, count: 5'd16});
        for (int i = 0; i < 5; i++) send(16'h0100, 1'b0);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h7777;
        idle(1);
        clr      = 1'b0;
        in_valid = 1'b0;
        send_frame(16'h0001, 16, 1'b0);
        idle(2);

        // async reset while holding discards the pending result
        out_ready = 1'b0;
        send_frame(16'h0100, 16, 1'b0);
        idle(1);
        rstn = 1'b0;
        #1;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_ready", 32'(in_ready), 32'd0);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        idle(1);
        chk("rst_release_ready", 32'(in_ready), 32'd1);
        exp_q.push_back('{data: 16'h0020, ovf: 1'b0, count: 5'd16});
        send_frame(16'h0002, 16, 1'b0);
        idle(4);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
